// File: rtl/thread_state_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | thread_state_mem                                                         |
// | Per-thread state store for the scheduler: CPU writes + external CAS.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module thread_state_mem #(
   parameter int N_THREADS     = 16,
   parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic [N_THREADS_MSB:0]            ts_rd_num,
   output logic [1:0]                        ts_rd,
   input  logic                              cpu_wr_en,
   input  logic [N_THREADS_MSB:0]            cpu_wr_num,
   input  logic [1:0]                        cpu_wr_state,
   input  logic                              ext_wr_en,
   input  logic [N_THREADS_MSB:0]            ext_wr_num,
   input  logic [1:0]                        ext_wr_expect,
   input  logic [1:0]                        ext_wr_state,
   output logic                              ext_wr_ack,
   output logic                              ext_wr_ok,
   input  logic [N_THREADS_MSB:0]            ext_rd_num,
   output logic [1:0]                        ext_rd_state,
   output logic [$clog2(N_THREADS+1)-1:0]    n_wr_rdy,
   output logic                              init_done
);

   localparam int              c_NUM_W     = N_THREADS_MSB + 1;
   localparam int              c_CNT_W     = $clog2(N_THREADS + 1);
   localparam logic [1:0]      c_TS_NONE   = 2'b00;
   localparam logic [1:0]      c_TS_WR_RDY = 2'b01;
   localparam logic [c_NUM_W:0]   c_N_EXT  = (c_NUM_W+1)'(N_THREADS);
   localparam logic [c_NUM_W-1:0] c_LAST   = c_NUM_W'(N_THREADS - 1);

   logic [1:0]          mem_q [N_THREADS];

   logic [c_NUM_W-1:0]  init_cnt_q,  init_cnt_d;
   logic                init_done_q, init_done_d;
   logic                stg_vld_q,   stg_vld_d;
   logic [c_NUM_W-1:0]  stg_num_q,   stg_num_d;
   logic [1:0]          stg_state_q, stg_state_d;
   logic [c_CNT_W-1:0]  n_wr_rdy_q,  n_wr_rdy_d;

   logic [1:0]          w_ts_cur;
   logic [1:0]          w_ext_rd_cur;
   logic [1:0]          w_ext_wr_cur;
   logic [1:0]          w_stg_old;
   logic                w_stage_hit;
   logic                w_cpu_take;
   logic                w_ack;
   logic                w_ok;
   logic                w_commit;

   // Thread numbers beyond N_THREADS-1 (non power-of-2 counts) read as NONE and are never written.
   function automatic logic in_range(input logic [c_NUM_W-1:0] num);
      return ({1'b0, num} < c_N_EXT);
   endfunction

   assign w_ts_cur     = in_range(ts_rd_num)  ? mem_q[ts_rd_num]  : c_TS_NONE;
   assign w_ext_rd_cur = in_range(ext_rd_num) ? mem_q[ext_rd_num] : c_TS_NONE;
   assign w_ext_wr_cur = in_range(ext_wr_num) ? mem_q[ext_wr_num] : c_TS_NONE;
   assign w_stg_old    = in_range(stg_num_q)  ? mem_q[stg_num_q]  : c_TS_NONE;

   // A staged write to the same thread would make the compare see a stale value.
   assign w_stage_hit = stg_vld_q & (stg_num_q == ext_wr_num);
   assign w_cpu_take  = cpu_wr_en & init_done_q & in_range(cpu_wr_num);
   assign w_ack       = ext_wr_en & init_done_q & ~cpu_wr_en & ~w_stage_hit;
   assign w_ok        = w_ack & in_range(ext_wr_num) & (w_ext_wr_cur == ext_wr_expect);
   assign w_commit    = init_done_q & stg_vld_q;

   always_comb begin
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      if (!init_done_q) begin
         if (init_cnt_q == c_LAST) begin
            init_done_d = 1'b1;
         end else begin
            init_cnt_d = init_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      stg_vld_d   = 1'b0;
      stg_num_d   = stg_num_q;
      stg_state_d = stg_state_q;
      if (w_cpu_take) begin
         stg_vld_d   = 1'b1;
         stg_num_d   = cpu_wr_num;
         stg_state_d = cpu_wr_state;
      end else if (w_ok) begin
         stg_vld_d   = 1'b1;
         stg_num_d   = ext_wr_num;
         stg_state_d = ext_wr_state;
      end
   end

   always_comb begin
      n_wr_rdy_d = n_wr_rdy_q;
      if (w_commit) begin
         case ({stg_state_q == c_TS_WR_RDY, w_stg_old == c_TS_WR_RDY})
            2'b10:   n_wr_rdy_d = n_wr_rdy_q + 1'b1;
            2'b01:   n_wr_rdy_d = n_wr_rdy_q - 1'b1;
            default: n_wr_rdy_d = n_wr_rdy_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         stg_vld_q   <= 1'b0;
         stg_num_q   <= '0;
         stg_state_q <= c_TS_NONE;
         n_wr_rdy_q  <= '0;
      end else begin
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         stg_vld_q   <= stg_vld_d;
         stg_num_q   <= stg_num_d;
         stg_state_q <= stg_state_d;
         n_wr_rdy_q  <= n_wr_rdy_d;
      end
   end

   // Storage has no reset; the sweep clears it one entry per cycle.
   always_ff @(posedge CLK) begin
      if (!init_done_q) begin
         mem_q[init_cnt_q] <= c_TS_NONE;
      end else if (stg_vld_q) begin
         mem_q[stg_num_q] <= stg_state_q;
      end
   end

   assign ts_rd        = init_done_q ? w_ts_cur     : c_TS_NONE;
   assign ext_rd_state = init_done_q ? w_ext_rd_cur : c_TS_NONE;
   assign ext_wr_ack   = w_ack;
   assign ext_wr_ok    = w_ok;
   assign n_wr_rdy     = n_wr_rdy_q;
   assign init_done    = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_thread_state_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_thread_state_mem                                                      |
// | Directed + random bench for thread_state_mem against a delay-line model. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_thread_state_mem;

   localparam int N  = 16;
   localparam int NW = 4;
   localparam int CW = 5;

   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S_WR   = 2'b01;
   localparam logic [1:0] S_RD   = 2'b10;
   localparam logic [1:0] S_BUSY = 2'b11;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [NW-1:0] ts_rd_num = '0;
   logic [1:0]    ts_rd;
   logic          cpu_wr_en = 1'b0;
   logic [NW-1:0] cpu_wr_num = '0;
   logic [1:0]    cpu_wr_state = '0;
   logic          ext_wr_en = 1'b0;
   logic [NW-1:0] ext_wr_num = '0;
   logic [1:0]    ext_wr_expect = '0;
   logic [1:0]    ext_wr_state = '0;
   logic          ext_wr_ack;
   logic          ext_wr_ok;
   logic [NW-1:0] ext_rd_num = '0;
   logic [1:0]    ext_rd_state;
   logic [CW-1:0] n_wr_rdy;
   logic          init_done;

   thread_state_mem #(.N_THREADS(N)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .ts_rd_num     (ts_rd_num),
      .ts_rd         (ts_rd),
      .cpu_wr_en     (cpu_wr_en),
      .cpu_wr_num    (cpu_wr_num),
      .cpu_wr_state  (cpu_wr_state),
      .ext_wr_en     (ext_wr_en),
      .ext_wr_num    (ext_wr_num),
      .ext_wr_expect (ext_wr_expect),
      .ext_wr_state  (ext_wr_state),
      .ext_wr_ack    (ext_wr_ack),
      .ext_wr_ok     (ext_wr_ok),
      .ext_rd_num    (ext_rd_num),
      .ext_rd_state  (ext_rd_state),
      .n_wr_rdy      (n_wr_rdy),
      .init_done     (init_done)
   );

   always #5 CLK = ~CLK;

   // Model: committed per-thread states plus writes still in flight (visible two cycles after acceptance).
   typedef struct {
      int         vis;
      int         num;
      logic [1:0] st;
   } wr_t;

   logic [1:0] mdl [N];
   wr_t        pend [$];
   int         cyc = 0;
   int         edges = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         last_ack = 1'b0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int wr_rdy_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (mdl[i] == S_WR) c++;
      return c;
   endfunction

   function automatic bit pending_to(input int n);
      foreach (pend[i]) if (pend[i].num == n) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      bit         done, ack, ok, acc_cpu, acc_ext;
      wr_t        w;
      @(negedge CLK);
      done = RST_N && (edges >= N);
      ack  = ext_wr_en && done && !cpu_wr_en && !pending_to(int'(ext_wr_num));
      ok   = ack && (mdl[ext_wr_num] == ext_wr_expect);
      chk("init_done",    8'(init_done),    8'(done));
      chk("ts_rd",        8'(ts_rd),        8'(done ? mdl[ts_rd_num] : S_NONE));
      chk("ext_rd_state", 8'(ext_rd_state), 8'(done ? mdl[ext_rd_num] : S_NONE));
      chk("ext_wr_ack",   8'(ext_wr_ack),   8'(ack));
      if (ack) chk("ext_wr_ok", 8'(ext_wr_ok), 8'(ok));
      chk("n_wr_rdy",     8'(n_wr_rdy),     8'(wr_rdy_count()));
      last_ack = ack;
      acc_cpu  = cpu_wr_en && done;
      acc_ext  = !acc_cpu && ok;
      w.vis = 0;
      w.num = acc_cpu ? int'(cpu_wr_num) : int'(ext_wr_num);
      w.st  = acc_cpu ? cpu_wr_state : ext_wr_state;
      @(posedge CLK);
      if (RST_N) begin
         if (edges < N) edges++;
         cyc++;
         for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].vis == cyc) begin
               mdl[pend[i].num] = pend[i].st;
               pend.delete(i);
            end
         end
         if (acc_cpu || acc_ext) begin
            w.vis = cyc + 1;
            pend.push_back(w);
         end
      end
      #1;
   endtask

   task automatic do_reset(input int hold);
      RST_N = 1'b0;
      pend.delete();
      for (int i = 0; i < N; i++) mdl[i] = S_NONE;
      edges = 0;
      repeat (hold) tick();
      RST_N = 1'b1;
   endtask

   task automatic cpu_wr(input int n, input logic [1:0] s);
      cpu_wr_en    = 1'b1;
      cpu_wr_num   = NW'(n);
      cpu_wr_state = s;
   endtask

   task automatic ext_req(input int n, input logic [1:0] e, input logic [1:0] s);
      ext_wr_en     = 1'b1;
      ext_wr_num    = NW'(n);
      ext_wr_expect = e;
      ext_wr_state  = s;
   endtask

   initial begin
      #1;
      // Reset and sweep; a CPU write in the middle of the sweep must be lost.
      do_reset(3);
      ts_rd_num  = 4'd9;
      ext_rd_num = 4'd9;
      for (int i = 0; i < 18; i++) begin
         if (i == 3) cpu_wr(9, S_WR); else cpu_wr_en = 1'b0;
         if (i == 5) ext_req(9, S_NONE, S_RD); else ext_wr_en = 1'b0;
         tick();
      end
      cpu_wr_en = 1'b0;
      ext_wr_en = 1'b0;
      tick();

      // CAS thread 3 NONE->WR_RDY, then the same CAS again (stalled, then fails).
      ts_rd_num  = 4'd3;
      ext_rd_num = 4'd3;
      ext_req(3, S_NONE, S_WR);
      tick();
      tick();
      tick();
      ext_wr_en = 1'b0;
      repeat (3) tick();

      // CPU and ext target thread 5 together: CPU wins, ext waits for the stage hit to clear.
      ts_rd_num = 4'd5;
      cpu_wr(5, S_BUSY);
      ext_req(5, S_BUSY, S_NONE);
      tick();
      cpu_wr_en = 1'b0;
      tick();
      tick();
      ext_wr_en = 1'b0;
      repeat (3) tick();

      // Ramp n_wr_rdy up then down.
      for (int i = 0; i < N; i++) begin
         cpu_wr(i, S_WR);
         ts_rd_num = NW'(i);
         tick();
      end
      for (int i = 0; i < N; i++) begin
         cpu_wr(i, S_NONE);
         ts_rd_num = NW'(i);
         tick();
      end
      cpu_wr_en = 1'b0;
      repeat (3) tick();

      // Reset while a write to thread 7 sits in the stage.
      ts_rd_num = 4'd7;
      cpu_wr(7, S_WR);
      tick();
      cpu_wr_en = 1'b0;
      do_reset(2);
      repeat (19) tick();

      // Scheduler view of thread 2: WR_RDY -> BUSY.
      ts_rd_num = 4'd2;
      cpu_wr(2, S_WR);
      tick();
      cpu_wr_en = 1'b0;
      repeat (2) tick();
      cpu_wr(2, S_BUSY);
      tick();
      cpu_wr_en = 1'b0;
      repeat (3) tick();

      // Random mix of both sources; ext requests held until acknowledged.
      for (int k = 0; k < 600; k++) begin
         int n;
         cpu_wr_en = ($urandom_range(0, 9) < 3);
         cpu_wr_num   = NW'($urandom_range(0, N - 1));
         cpu_wr_state = 2'($urandom_range(0, 3));
         if (!ext_wr_en || last_ack) begin
            if ($urandom_range(0, 9) < 5) begin
               n = $urandom_range(0, N - 1);
               ext_req(n, ($urandom_range(0, 1) == 1) ? mdl[n] : 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)));
            end else begin
               ext_wr_en = 1'b0;
            end
         end
         ts_rd_num  = NW'($urandom_range(0, N - 1));
         ext_rd_num = NW'($urandom_range(0, N - 1));
         tick();
      end
      cpu_wr_en = 1'b0;
      ext_wr_en = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/thread_state_mem.md
# thread_state_mem

Per-thread state store feeding the CPU thread scheduler (`thread_number`). It holds one `THREAD_STATE_*` code per thread, serves the scheduler's look-ahead read port, and accepts state writes from two sources: the CPU (suspend/finish on the running thread) and the external load/unload unit (compare-and-set with handshake). Write-to-read propagation is exactly 2 cycles, which matches the scheduler's same-thread reselect delay (`TS_DELAY = 2`).

## Interface
- `N_THREADS`, 16, number of threads; any value ≥2, not necessarily a power of 2
- `N_THREADS_MSB`, `` `MSB(N_THREADS-1) ``, thread-number MSB
- State codes (`` `THREAD_STATE_MSB `` = 1): NONE=2'b00, WR_RDY=2'b01, RD_RDY=2'b10, BUSY=2'b11

Ports:
- `CLK`  in  1  single clock, all logic on posedge
- `RST_N`  in  1  asynchronous, active-low reset
- `ts_rd_num`  in  N_THREADS_MSB+1  scheduler read address
- `ts_rd`  out  2  state of `ts_rd_num`, combinational read
- `cpu_wr_en`  in  1  CPU state write strobe
- `cpu_wr_num`  in  N_THREADS_MSB+1  CPU write thread
- `cpu_wr_state`  in  2  CPU new state
- `ext_wr_en`  in  1  external write request, held until `ext_wr_ack`
- `ext_wr_num`  in  N_THREADS_MSB+1  external write thread
- `ext_wr_expect`  in  2  required current state
- `ext_wr_state`  in  2  new state
- `ext_wr_ack`  out  1  request consumed this cycle (combinational)
- `ext_wr_ok`  out  1  valid with ack: compare matched, write issued
- `ext_rd_num`  in  N_THREADS_MSB+1  external read address
- `ext_rd_state`  out  2  state of `ext_rd_num`, combinational
- `n_wr_rdy`  out  `` `MSB(N_THREADS) ``+1  count of threads in WR_RDY (registered)
- `init_done`  out  1  init sweep finished (registered)

## Operation
- Storage: N_THREADS×2 distributed RAM, async read, one sync write port; no reset on the array itself.
- Init sweep: on `RST_N` low → `init_cnt`=0, `init_done`=0, write stage invalid, `n_wr_rdy`=0. After release, one array write of NONE per cycle to addresses 0..N_THREADS-1; `init_done` rises on the edge that writes N_THREADS-1. During sweep: `ts_rd` and `ext_rd_state` forced NONE, `ext_wr_ack`=0, `cpu_wr_en` ignored (dropped).
- Write stage: single register {valid, num, state}. Loaded each cycle from the winning source; on the next edge it writes the array and updates `n_wr_rdy`.
- Arbitration: CPU has priority. `ext_wr_ack` = `ext_wr_en` & `init_done` & ~`cpu_wr_en` & ~(stage valid & stage num == `ext_wr_num`).
- Compare-and-set: at ack, `ext_wr_ok` = (array[`ext_wr_num`] == `ext_wr_expect`); the stage is loaded only if ok. A failed compare still consumes the request (ack=1, ok=0), and nothing is written.
- CPU writes are unconditional; no compare.
- Counter: on the array-write edge, `n_wr_rdy` += (new==WR_RDY) − (old==WR_RDY), where old is the array value at commit. A WR_RDY→WR_RDY write leaves it unchanged. Range 0..N_THREADS; no wrap is possible.
- No read bypass: `ts_rd` shows only committed array contents.

## Timing
- Write presented (CPU, or acked ext) in cycle t → stage loaded at edge t → array written at edge t+1 → visible on `ts_rd`/`ext_rd_state` in cycle t+2 → `n_wr_rdy` updated in cycle t+2.
- Back-to-back writes: one per cycle sustained, from either source.
- Simultaneous CPU+ext: CPU is staged and ext is not acked; ext is acked in the first later cycle with no CPU write and no same-thread stage hit.
- Same-thread stall: ext to thread k while stage holds k → ack deferred exactly 1 cycle (assuming no CPU write), so the compare sees the committed value.
- Reset asserted mid-operation: pending stage discarded, sweep restarts from 0; `init_done` is low 1 cycle after `RST_N` rises through N_THREADS cycles.
- Reset values: `ts_rd`=NONE, `ext_rd_state`=NONE, `ext_wr_ack`=0, `ext_wr_ok`=0, `n_wr_rdy`=0, `init_done`=0.

## Test plan
- Reset, N_THREADS=16: `init_done` low for 16 cycles after release, then 1. All `ts_rd` reads return NONE. `n_wr_rdy`=0. A CPU write issued during the sweep is lost.
- Ext CAS thread 3 NONE→WR_RDY at cycle t: ack=1, ok=1. `ts_rd`(3)=WR_RDY from t+2. `n_wr_rdy`=1 at t+2. A repeat of the same CAS returns ok=0 with no count change.
- CPU writes thread 5 BUSY and ext requests thread 5 in the same cycle: ext ack=0 for that cycle and the next (stage hit). Ext is acked at t+2 and compares against BUSY.
- CPU writes WR_RDY to all 16 threads back-to-back, then NONE to all: `n_wr_rdy` ramps 0→16→0, one step per cycle, each step 2 cycles after its write.
- Assert `RST_N` low with a pending stage write to thread 7 (WR_RDY): after the re-sweep, thread 7 = NONE and `n_wr_rdy`=0.
- Scheduler check: thread 2 WR_RDY→BUSY by CPU at t. `ts_rd`(2) still WR_RDY in t+1 and BUSY from t+2.
